rggen_axi4lite_bus_sequencer: RTL and testbench

Sits downstream of the AXI4-lite skid buffer and converts AXI4-lite transactions into single-outstanding accesses on the local register bus. It arbitrates between read and write requests with alternating priority and holds each request until the register bus completes it. It then returns the AXI4-lite response and only afterwards accepts the next request.

---
 rtl/rggen_axi4lite_seq_pkg.sv | 26 ++
 rtl/rggen_axi4lite_rw_arbiter.sv | 49 ++++
 rtl/rggen_axi4lite_bus_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_rggen_axi4lite_bus_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_axi4lite_seq_pkg.sv
// ---------------------------------------------------------------------------
// rggen_axi4lite_seq_pkg
// Shared definitions for the AXI4-lite to register-bus sequencer:
//   - seq_state_e        : sequencer states (IDLE, BUS_ACCESS, RESPONSE)
//   - RESP_OKAY/SLVERR   : AXI4-lite response encodings
//   - TIMEOUT_*          : bus access watchdog limit, used only when the
//                          RGGEN_BUS_TIMEOUT_EN macro is defined
// ---------------------------------------------------------------------------
package rggen_axi4lite_seq_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUS_ACCESS = 2'd1,
        RESPONSE   = 2'd2
    } seq_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A bus access is abandoned after this many cycles without i_bus_ready.
    localparam int                              TIMEOUT_LIMIT         = 256;
    localparam int                              TIMEOUT_COUNTER_WIDTH = 8;
    localparam logic [TIMEOUT_COUNTER_WIDTH-1:0] TIMEOUT_LAST         =
        TIMEOUT_COUNTER_WIDTH'(TIMEOUT_LIMIT - 1);

endpackage

// File: rtl/rggen_axi4lite_rw_arbiter.sv
// ---------------------------------------------------------------------------
// rggen_axi4lite_rw_arbiter
// Picks between a pending AXI write (needs both awvalid and wvalid) and a
// pending AXI read. When both are pending, a priority flag decides. The
// flag is flipped to favour the other access type each time a
// transaction's response handshake completes.
// Ports:
//   clk, rst_n   : clock, async active-low reset (flag resets to read-first)
//   enable       : sequencer can accept a request this cycle
//   awvalid,
//   wvalid,
//   arvalid      : AXI request valids
//   done         : response handshake of the current transaction
//   done_write   : the completed transaction was a write
//   grant_write  : write accepted this cycle (drives awready/wready)
//   grant_read   : read accepted this cycle (drives arready)
// ---------------------------------------------------------------------------
module rggen_axi4lite_rw_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic awvalid,
    input  logic wvalid,
    input  logic arvalid,
    input  logic done,
    input  logic done_write,
    output logic grant_write,
    output logic grant_read
);

    logic read_first;
    logic write_eligible;

    // After a write completes reads get priority, and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_first <= 1'b1;
        end else if (done) begin
            read_first <= done_write;
        end
    end

    // A half-presented write (address without data or the reverse) is not
    // eligible, so it can never block a read.
    assign write_eligible = awvalid && wvalid;
    assign grant_read     = enable && arvalid && (!write_eligible || read_first);
    assign grant_write    = enable && write_eligible && (!arvalid || !read_first);

endmodule

// File: rtl/rggen_axi4lite_bus_sequencer.sv
// ---------------------------------------------------------------------------
// rggen_axi4lite_bus_sequencer
// Converts AXI4-lite transactions into single-outstanding accesses on the
// local register bus: IDLE -> BUS_ACCESS -> RESPONSE -> IDLE.
// Optional macro RGGEN_BUS_TIMEOUT_EN: abandons a bus access with SLVERR if
// i_bus_ready has not arrived within TIMEOUT_LIMIT cycles.
// Ports:
//   i_clk, i_rst_n            : clock, async active-low reset
//   AXI write address/data    : i_awvalid/o_awready/i_awaddr,
//                               i_wvalid/o_wready/i_wdata/i_wstrb
//   AXI write response        : o_bvalid/i_bready/o_bresp
//   AXI read address          : i_arvalid/o_arready/i_araddr
//   AXI read data             : o_rvalid/i_rready/o_rresp/o_rdata
//   Register bus request      : o_bus_valid/o_bus_write/o_bus_address/
//                               o_bus_write_data/o_bus_strobe
//   Register bus completion   : i_bus_ready/i_bus_error/i_bus_read_data
// ---------------------------------------------------------------------------
module rggen_axi4lite_bus_sequencer
    import rggen_axi4lite_seq_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_awvalid,
    output logic                     o_awready,
    input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
    input  logic                     i_wvalid,
    output logic                     o_wready,
    input  logic [BUS_WIDTH-1:0]     i_wdata,
    input  logic [BUS_WIDTH/8-1:0]   i_wstrb,
    output logic                     o_bvalid,
    input  logic                     i_bready,
    output logic [1:0]               o_bresp,
    input  logic                     i_arvalid,
    output logic                     o_arready,
    input  logic [ADDRESS_WIDTH-1:0] i_araddr,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic [1:0]               o_rresp,
    output logic [BUS_WIDTH-1:0]     o_rdata,
    output logic                     o_bus_valid,
    output logic                     o_bus_write,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [BUS_WIDTH-1:0]     o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
    input  logic                     i_bus_ready,
    input  logic                     i_bus_error,
    input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

    localparam int STROBE_WIDTH = BUS_WIDTH / 8;

    seq_state_e               state;
    seq_state_e               next_state;
    logic                     grant_write;
    logic                     grant_read;
    logic                     response_done;
    logic                     timeout;
    logic                     access_write;
    logic [ADDRESS_WIDTH-1:0] access_address;
    logic [BUS_WIDTH-1:0]     access_data;
    logic [STROBE_WIDTH-1:0]  access_strobe;
    logic                     response_error;
    logic [BUS_WIDTH-1:0]     response_data;

    // Readies are gated by reset so every output is 0 while reset is held.
    rggen_axi4lite_rw_arbiter u_arbiter (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .enable      ((state == IDLE) && i_rst_n),
        .awvalid     (i_awvalid),
        .wvalid      (i_wvalid),
        .arvalid     (i_arvalid),
        .done        (response_done),
        .done_write  (access_write),
        .grant_write (grant_write),
        .grant_read  (grant_read)
    );

    assign response_done = (state == RESPONSE) &&
                           (access_write ? i_bready : i_rready);

`ifdef RGGEN_BUS_TIMEOUT_EN
    logic [TIMEOUT_COUNTER_WIDTH-1:0] timeout_count;

    // Counts cycles spent waiting in BUS_ACCESS; cleared everywhere else.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timeout_count <= '0;
        end else if (state != BUS_ACCESS) begin
            timeout_count <= '0;
        end else begin
            timeout_count <= timeout_count + 1'b1;
        end
    end

    assign timeout = (state == BUS_ACCESS) && !i_bus_ready &&
                     (timeout_count == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_write || grant_read) begin
                    next_state = BUS_ACCESS;
                end
            end
            BUS_ACCESS: begin
                if (i_bus_ready || timeout) begin
                    next_state = RESPONSE;
                end
            end
            RESPONSE: begin
                if (response_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured on the grant cycle and held until the
    // next grant, so the bus sees them stable for the whole access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            access_write   <= 1'b0;
            access_address <= '0;
            access_data    <= '0;
            access_strobe  <= '0;
        end else if (grant_write) begin
            access_write   <= 1'b1;
            access_address <= i_awaddr;
            access_data    <= i_wdata;
            access_strobe  <= i_wstrb;
        end else if (grant_read) begin
            access_write   <= 1'b0;
            access_address <= i_araddr;
            access_data    <= '0;
            access_strobe  <= '0;
        end
    end

    // Completion status is sampled only inside BUS_ACCESS, so a ready that
    // arrives after a timeout has no effect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            response_error <= 1'b0;
            response_data  <= '0;
        end else if (state == BUS_ACCESS) begin
            if (i_bus_ready) begin
                response_error <= i_bus_error;
                response_data  <= i_bus_read_data;
            end else if (timeout) begin
                response_error <= 1'b1;
                response_data  <= '0;
            end
        end
    end

    assign o_awready        = grant_write;
    assign o_wready         = grant_write;
    assign o_arready        = grant_read;

    assign o_bus_valid      = (state == BUS_ACCESS);
    assign o_bus_write      = access_write;
    assign o_bus_address    = access_address;
    assign o_bus_write_data = access_data;
    assign o_bus_strobe     = access_strobe;

    assign o_bvalid = (state == RESPONSE) && access_write;
    assign o_rvalid = (state == RESPONSE) && !access_write;
    assign o_bresp  = (o_bvalid && response_error) ? RESP_SLVERR : RESP_OKAY;
    assign o_rresp  = (o_rvalid && response_error) ? RESP_SLVERR : RESP_OKAY;
    assign o_rdata  = (o_rvalid && !response_error) ? response_data : '0;

endmodule

// File: tb/tb_rggen_axi4lite_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rggen_axi4lite_bus_sequencer
// Self-checking bench: a table of single transactions with hand-computed
// bus fields and responses, followed by directed sequences for arbitration
// priority, half-presented writes, held error responses and mid-access
// reset.
// ---------------------------------------------------------------------------
module tb_rggen_axi4lite_bus_sequencer;

    localparam int AW = 8;
    localparam int BW = 32;
    localparam int SW = BW / 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_awvalid, o_awready;
    logic [AW-1:0] i_awaddr;
    logic          i_wvalid, o_wready;
    logic [BW-1:0] i_wdata;
    logic [SW-1:0] i_wstrb;
    logic          o_bvalid, i_bready;
    logic [1:0]    o_bresp;
    logic          i_arvalid, o_arready;
    logic [AW-1:0] i_araddr;
    logic          o_rvalid, i_rready;
    logic [1:0]    o_rresp;
    logic [BW-1:0] o_rdata;
    logic          o_bus_valid, o_bus_write;
    logic [AW-1:0] o_bus_address;
    logic [BW-1:0] o_bus_write_data;
    logic [SW-1:0] o_bus_strobe;
    logic          i_bus_ready, i_bus_error;
    logic [BW-1:0] i_bus_read_data;

    rggen_axi4lite_bus_sequencer #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
        .o_bus_valid(o_bus_valid), .o_bus_write(o_bus_write), .o_bus_address(o_bus_address),
        .o_bus_write_data(o_bus_write_data), .o_bus_strobe(o_bus_strobe),
        .i_bus_ready(i_bus_ready), .i_bus_error(i_bus_error), .i_bus_read_data(i_bus_read_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          is_write;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            latency;
        logic          bus_error;
        logic [BW-1:0] bus_rdata;
        logic [1:0]    exp_resp;
        logic [BW-1:0] exp_rdata;
    } vector_t;

    vector_t vectors[6];
    int      checks = 0;
    int      errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clearInputs();
        i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
        i_bready = 0; i_rready = 0;
        i_bus_ready = 0; i_bus_error = 0; i_bus_read_data = '0;
    endtask

    // Bus reports completion this cycle; returns one cycle later in RESPONSE.
    task automatic completeAccess(input logic err, input logic [BW-1:0] rd);
        i_bus_ready = 1; i_bus_error = err; i_bus_read_data = rd;
        step();
        i_bus_ready = 0; i_bus_error = 0; i_bus_read_data = '0;
        #1;
    endtask

    task automatic respond();
        i_bready = 1; i_rready = 1;
        step();
        i_bready = 0; i_rready = 0;
        #1;
    endtask

    // Runs one full transaction from IDLE and checks every phase of it.
    task automatic applyStimulus(input vector_t v, input string tag);
        if (v.is_write) begin
            i_awvalid = 1; i_wvalid = 1;
            i_awaddr = v.addr; i_wdata = v.wdata; i_wstrb = v.wstrb;
        end else begin
            i_arvalid = 1; i_araddr = v.addr;
        end
        #1;
        checkOutput({tag, " awready"}, o_awready, v.is_write);
        checkOutput({tag, " arready"}, o_arready, !v.is_write);
        step();
        i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
        i_awaddr = ~v.addr; i_araddr = ~v.addr; i_wdata = ~v.wdata; i_wstrb = ~v.wstrb;
        for (int c = 0; c <= v.latency; c++) begin
            if (c == v.latency) begin
                i_bus_ready = 1; i_bus_error = v.bus_error; i_bus_read_data = v.bus_rdata;
            end
            #1;
            checkOutput({tag, " bus_valid"}, o_bus_valid, 1'b1);
            checkOutput({tag, " bus_write"}, o_bus_write, v.is_write);
            checkOutput({tag, " bus_address"}, o_bus_address, v.addr);
            checkOutput({tag, " bus_write_data"}, o_bus_write_data, v.is_write ? v.wdata : '0);
            checkOutput({tag, " bus_strobe"}, o_bus_strobe, v.is_write ? v.wstrb : '0);
            step();
        end
        i_bus_ready = 0; i_bus_error = 0; i_bus_read_data = '0;
        #1;
        checkOutput({tag, " resp bus_valid"}, o_bus_valid, 1'b0);
        checkOutput({tag, " bvalid"}, o_bvalid, v.is_write);
        checkOutput({tag, " rvalid"}, o_rvalid, !v.is_write);
        if (v.is_write) begin
            checkOutput({tag, " bresp"}, o_bresp, v.exp_resp);
        end else begin
            checkOutput({tag, " rresp"}, o_rresp, v.exp_resp);
            checkOutput({tag, " rdata"}, o_rdata, v.exp_rdata);
        end
        respond();
        checkOutput({tag, " idle bvalid"}, o_bvalid, 1'b0);
        checkOutput({tag, " idle rvalid"}, o_rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        vectors[0] = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1, 1'b0, 32'h0,        2'b00, 32'h0};
        vectors[1] = '{1'b0, 8'h10, 32'h0,        4'h0, 2, 1'b0, 32'h12345678, 2'b00, 32'h12345678};
        vectors[2] = '{1'b1, 8'h08, 32'h0000A5A5, 4'h3, 0, 1'b1, 32'h0,        2'b10, 32'h0};
        vectors[3] = '{1'b0, 8'h20, 32'h0,        4'h0, 0, 1'b1, 32'hCAFEF00D, 2'b10, 32'h0};
        vectors[4] = '{1'b0, 8'hFC, 32'h0,        4'h0, 1, 1'b0, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFF};
        vectors[5] = '{1'b1, 8'hFF, 32'h11223344, 4'h0, 0, 1'b0, 32'h0,        2'b00, 32'h0};

        // Reset with all request valids asserted: nothing may respond.
        clearInputs();
        i_awaddr = '0; i_araddr = '0; i_wdata = '0; i_wstrb = '0;
        i_rst_n = 0;
        i_awvalid = 1; i_wvalid = 1; i_arvalid = 1;
        #12;
        checkOutput("reset awready", o_awready, 1'b0);
        checkOutput("reset wready", o_wready, 1'b0);
        checkOutput("reset arready", o_arready, 1'b0);
        checkOutput("reset bus_valid", o_bus_valid, 1'b0);
        checkOutput("reset bvalid", o_bvalid, 1'b0);
        checkOutput("reset rvalid", o_rvalid, 1'b0);
        checkOutput("reset bus_address", o_bus_address, 8'h00);
        checkOutput("reset rdata", o_rdata, 32'h0);
        clearInputs();
        @(negedge i_clk);
        i_rst_n = 1;
        step();

        // Arbitration: read first after reset, then write, then read again.
        i_awvalid = 1; i_wvalid = 1; i_arvalid = 1;
        i_awaddr = 8'h30; i_wdata = 32'h55; i_wstrb = 4'hF; i_araddr = 8'h40;
        #1;
        checkOutput("arb1 arready", o_arready, 1'b1);
        checkOutput("arb1 awready", o_awready, 1'b0);
        checkOutput("arb1 wready", o_wready, 1'b0);
        step();
        i_arvalid = 0;
        #1;
        checkOutput("arb1 bus_write", o_bus_write, 1'b0);
        checkOutput("arb1 bus_address", o_bus_address, 8'h40);
        checkOutput("arb1 busy awready", o_awready, 1'b0);
        completeAccess(1'b0, 32'h1);
        respond();
        checkOutput("arb2 awready", o_awready, 1'b1);
        checkOutput("arb2 wready", o_wready, 1'b1);
        step();
        i_awvalid = 0; i_wvalid = 0;
        #1;
        checkOutput("arb2 bus_write", o_bus_write, 1'b1);
        checkOutput("arb2 bus_address", o_bus_address, 8'h30);
        completeAccess(1'b0, 32'h0);
        respond();
        i_awvalid = 1; i_wvalid = 1; i_arvalid = 1;
        #1;
        checkOutput("arb3 arready", o_arready, 1'b1);
        checkOutput("arb3 awready", o_awready, 1'b0);
        step();
        i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
        #1;
        checkOutput("arb3 bus_write", o_bus_write, 1'b0);
        completeAccess(1'b0, 32'h0);
        respond();

        // Table of single transactions.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vectors[i], $sformatf("vec%0d", i));
        end

        // Lone awvalid is never accepted until wvalid joins it.
        i_awvalid = 1; i_awaddr = 8'h44; i_wdata = 32'h9; i_wstrb = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("lone c%0d awready", c), o_awready, 1'b0);
            checkOutput($sformatf("lone c%0d wready", c), o_wready, 1'b0);
            checkOutput($sformatf("lone c%0d bus_valid", c), o_bus_valid, 1'b0);
            step();
        end
        i_wvalid = 1;
        #1;
        checkOutput("lone joined awready", o_awready, 1'b1);
        checkOutput("lone joined wready", o_wready, 1'b1);
        step();
        i_awvalid = 0; i_wvalid = 0;
        #1;
        checkOutput("lone bus_valid", o_bus_valid, 1'b1);
        checkOutput("lone bus_address", o_bus_address, 8'h44);
        completeAccess(1'b0, 32'h0);
        checkOutput("lone bvalid", o_bvalid, 1'b1);
        checkOutput("lone bresp", o_bresp, 2'b00);
        respond();

        // Error read held while rready is low; arvalid kept high meanwhile.
        i_arvalid = 1; i_araddr = 8'h50;
        #1;
        step();
        #1;
        checkOutput("err busy arready", o_arready, 1'b0);
        completeAccess(1'b1, 32'hAAAA5555);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("err c%0d rvalid", c), o_rvalid, 1'b1);
            checkOutput($sformatf("err c%0d rresp", c), o_rresp, 2'b10);
            checkOutput($sformatf("err c%0d rdata", c), o_rdata, 32'h0);
            checkOutput($sformatf("err c%0d arready", c), o_arready, 1'b0);
            step();
        end
        i_arvalid = 0; i_rready = 1;
        step();
        i_rready = 0;
        #1;
        checkOutput("err done rvalid", o_rvalid, 1'b0);

        // Reset in the middle of a bus access discards the transaction.
        i_awvalid = 1; i_wvalid = 1; i_awaddr = 8'h60; i_wdata = 32'h77; i_wstrb = 4'hF;
        #1;
        step();
        i_awvalid = 0; i_wvalid = 0;
        #1;
        checkOutput("rst mid bus_valid before", o_bus_valid, 1'b1);
        i_rst_n = 0;
        #1;
        checkOutput("rst mid bus_valid async", o_bus_valid, 1'b0);
        checkOutput("rst mid bvalid", o_bvalid, 1'b0);
        step();
        step();
        @(negedge i_clk);
        i_rst_n = 1;
        step();
        step();
        checkOutput("rst after bvalid", o_bvalid, 1'b0);
        checkOutput("rst after rvalid", o_rvalid, 1'b0);
        checkOutput("rst after bus_valid", o_bus_valid, 1'b0);
        applyStimulus(vectors[1], "post reset read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
